// File: rtl/sigdiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : sigdiv_seq
// Purpose  : Iterative radix-2 restoring significand divider for the FP
//            divide path. Produces floor((a << (NSIG+2)) / b) one quotient
//            bit per clock, MSB first, plus a sticky bit for rounding and a
//            divide-by-zero flag. Start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
module sigdiv_seq #(
    parameter int NSIG = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NSIG:0]   a,
    input  logic [NSIG:0]   b,
    output logic            busy,
    output logic            done,
    output logic [NSIG+2:0] q,
    output logic            sticky,
    output logic            dz
);

    // Iteration count: one integer bit, NSIG fraction bits, guard, round.
    localparam int                c_CNT_W    = $clog2(NSIG + 4);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(NSIG + 3);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_DIV  = 1'b1;

    logic [0:0]        r_state;
    logic [NSIG+1:0]   r_rem;
    logic [NSIG:0]     r_b;
    logic [c_CNT_W-1:0] r_cnt;
    logic [NSIG+2:0]   r_q;
    logic              r_busy;
    logic              r_done;
    logic              r_sticky;
    logic              r_dz;

    logic [0:0]        w_state_nxt;
    logic [NSIG+1:0]   w_rem_nxt;
    logic [NSIG:0]     w_b_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [NSIG+2:0]   w_q_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_sticky_nxt;
    logic              w_dz_nxt;

    logic              w_ge;
    logic [NSIG+1:0]   w_diff;
    logic [NSIG+1:0]   w_rem_p;

    // Restoring step: subtract the divisor when it fits, keep remainder otherwise.
    always_comb begin
        w_ge    = (r_rem >= {1'b0, r_b});
        w_diff  = r_rem - {1'b0, r_b};
        w_rem_p = w_ge ? w_diff : r_rem;
    end

    // Next-state and datapath update; every register holds unless changed below.
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_b_nxt      = r_b;
        w_cnt_nxt    = r_cnt;
        w_q_nxt      = r_q;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_sticky_nxt = r_sticky;
        w_dz_nxt     = r_dz;

        if (r_state == c_ST_IDLE) begin
            if (r_busy) begin
                // Busy while idle only happens for a zero divisor: report it now.
                w_busy_nxt   = 1'b0;
                w_done_nxt   = 1'b1;
                w_q_nxt      = '1;
                w_sticky_nxt = 1'b1;
                w_dz_nxt     = 1'b1;
            end else if (start) begin
                w_busy_nxt = 1'b1;
                w_q_nxt    = '0;
                w_dz_nxt   = 1'b0;
                if (b != '0) begin
                    w_b_nxt     = b;
                    w_rem_nxt   = {1'b0, a};
                    w_cnt_nxt   = c_CNT_INIT;
                    w_state_nxt = c_ST_DIV;
                end
            end
        end else begin
            // Remainder stays below 2b, so dropping the top bit on the shift is safe.
            w_rem_nxt = {w_rem_p[NSIG:0], 1'b0};
            w_q_nxt   = {r_q[NSIG+1:0], w_ge};
            w_cnt_nxt = r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
                w_state_nxt  = c_ST_IDLE;
                w_busy_nxt   = 1'b0;
                w_done_nxt   = 1'b1;
                w_sticky_nxt = (w_rem_p != '0);
            end
        end
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_rem    <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_q      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sticky <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rem    <= w_rem_nxt;
            r_b      <= w_b_nxt;
            r_cnt    <= w_cnt_nxt;
            r_q      <= w_q_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_sticky <= w_sticky_nxt;
            r_dz     <= w_dz_nxt;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign q      = r_q;
    assign sticky = r_sticky;
    assign dz     = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_sigdiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigdiv_seq
// Purpose  : Self-checking bench for sigdiv_seq (NSIG=10). Expected results
//            are queued at each accept and compared when done pulses.
// Revision : 1.0  initial release
// ============================================================================
module tb_sigdiv_seq;

    localparam int NSIG = 10;
    localparam int c_LAT = NSIG + 3;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [NSIG:0]   a;
    logic [NSIG:0]   b;
    logic            busy;
    logic            done;
    logic [NSIG+2:0] q;
    logic            sticky;
    logic            dz;

    sigdiv_seq #(.NSIG(NSIG)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .q      (q),
        .sticky (sticky),
        .dz     (dz)
    );

    typedef struct {
        logic [NSIG+2:0] q;
        logic            sticky;
        logic            dz;
        int              acc;
    } exp_t;

    exp_t sb[$];
    exp_t r_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   busy_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time accept-to-done latency.
    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: quotient and sticky of (a << (NSIG+2)) / b, or the zero-divisor result.
    function automatic exp_t model(input logic [NSIG:0] aa, input logic [NSIG:0] bb, input int acc);
        exp_t e;
        logic [63:0] num;
        num   = 64'(aa) << (NSIG + 2);
        e.acc = acc;
        if (bb == '0) begin
            e.q      = '1;
            e.sticky = 1'b1;
            e.dz     = 1'b1;
        end else begin
            e.q      = (NSIG+3)'(num / 64'(bb));
            e.sticky = ((num % 64'(bb)) != 0);
            e.dz     = 1'b0;
        end
        return e;
    endfunction

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 32'(done), 32'd0);
            end else begin
                r_e = sb.pop_front();
                check_val("q", 32'(q), 32'(r_e.q));
                check_val("sticky", 32'(sticky), 32'(r_e.sticky));
                check_val("dz", 32'(dz), 32'(r_e.dz));
                check_val("latency", 32'(cyc), 32'(r_e.acc + (r_e.dz ? 1 : c_LAT)));
            end
        end
    end

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_val(tag, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // One operation from idle; optional noise drives start/operands while busy.
    task automatic do_op(input logic [NSIG:0] aa, input logic [NSIG:0] bb, input bit noise);
        @(negedge clk);
        a     = aa;
        b     = bb;
        start = 1'b1;
        sb.push_back(model(aa, bb, cyc + 1));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0 && bb != '0) begin
                check_val("q_clear_at_accept", 32'(q), 32'd0);
                check_val("dz_clear_at_accept", 32'(dz), 32'd0);
            end
            if (noise && bb != '0) begin
                start = 1'($urandom);
                a     = (NSIG+1)'($urandom);
                b     = (NSIG+1)'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain("done_timeout");
    endtask

    function automatic logic [NSIG:0] rnd_norm();
        return (NSIG+1)'(11'h400 | (11'($urandom) & 11'h3FF));
    endfunction

    initial begin
        int next_acc;
        int pushed;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_q", 32'(q), 32'd0);
        check_val("rst_sticky", 32'(sticky), 32'd0);
        check_val("rst_dz", 32'(dz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Unity quotient, with busy width measured.
        busy_cnt = 0;
        do_op(11'h400, 11'h400, 1'b0);
        check_val("busy_cycles", 32'(busy_cnt), 32'(c_LAT));

        // Directed quotients.
        do_op(11'h7FF, 11'h400, 1'b0);
        do_op(11'h400, 11'h600, 1'b0);
        do_op(11'h400, 11'h7FF, 1'b0);

        // Zero divisor, then a normal op must clear dz.
        busy_cnt = 0;
        do_op(11'h5A5, 11'h000, 1'b0);
        check_val("dz_busy_cycles", 32'(busy_cnt), 32'd1);
        do_op(11'h5A5, 11'h4C3, 1'b0);

        // Start held high with fresh operands every cycle.
        next_acc = 0;
        pushed   = 0;
        while (pushed < 5) begin
            @(negedge clk);
            a     = rnd_norm();
            b     = rnd_norm();
            start = 1'b1;
            if (pushed == 0 || cyc + 1 == next_acc) begin
                sb.push_back(model(a, b, cyc + 1));
                next_acc = cyc + 1 + c_LAT + 1;
                pushed++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain("held_start_timeout");

        // Asynchronous reset mid-operation.
        do_op_abort();

        do_op(11'h7FF, 11'h400, 1'b0);

        // Random normalized operands with mid-op noise.
        for (int k = 0; k < 400; k++) begin
            do_op(rnd_norm(), rnd_norm(), 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic do_op_abort();
        @(negedge clk);
        a     = 11'h7FF;
        b     = 11'h400;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_q", 32'(q), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Monitor flags any done that shows up with an empty scoreboard.
        repeat (20) @(negedge clk);
        check_val("abort_idle", 32'(busy), 32'd0);
    endtask

endmodule
`default_nettype wire
